inta_initiator: RTL and testbench
=================================

INTA_INITIATOR -- requirements
Module: inta_initiator

Interface
REQ-001 SHALL have parameter PULSE_LOW, default 2: cycles INTA is held low per pulse; legal 1..15, 0 behaves as 1.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: cycles INTA is high between pulses and in recovery; legal 1..15, 0 behaves as 1.
REQ-003 SHALL have port CLK input 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port RESET input 1: synchronous, active-high reset.
REQ-005 SHALL have port INT input 1: interrupt request from the priority resolver, active high.
REQ-006 SHALL have port IF_EN input 1: CPU interrupt-enable flag; 1 permits a new acknowledge sequence.
REQ-007 SHALL have port BUSY input 1: CPU mid-instruction; 1 blocks a new sequence.
REQ-008 SHALL have port D input 8: vector byte driven by the controller during the second INTA pulse.
REQ-009 SHALL have port INTA output 1: interrupt acknowledge, active low, registered.
REQ-010 SHALL have port VECTOR output 8: last captured vector, registered.
REQ-011 SHALL have port VECTOR_VALID output 1: one-cycle pulse when VECTOR is updated.
REQ-012 SHALL have port ACK_ACTIVE output 1: high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement states IDLE, P1_LOW, GAP, P2_LOW, RECOVER with a 4-bit down-counter.
REQ-014 In IDLE, at an edge with INT=1, IF_EN=1, BUSY=0, SHALL enter P1_LOW and drive INTA=0 from the next cycle, no combinational path.
REQ-015 P1_LOW SHALL hold INTA=0 exactly PULSE_LOW cycles, then enter GAP.
REQ-016 GAP SHALL hold INTA=1 exactly GAP_CYCLES cycles, then enter P2_LOW.
REQ-017 P2_LOW SHALL hold INTA=0 exactly PULSE_LOW cycles and sample D on its final cycle.
REQ-018 On leaving P2_LOW, SHALL load VECTOR with the sampled byte, pulse VECTOR_VALID for exactly the first RECOVER cycle, and drive INTA=1.
REQ-019 RECOVER SHALL last GAP_CYCLES cycles, ignore INT, then return to IDLE; a still-high INT may start a new sequence from IDLE.
REQ-020 Once started, a sequence SHALL ignore IF_EN and BUSY changes until IDLE.
REQ-021 Without INTA_SPURIOUS_EN, INT deassertion mid-sequence SHALL be ignored and both pulses completed.
REQ-022 Each acknowledge SHALL produce exactly two INTA low pulses; total length 2*PULSE_LOW+2*GAP_CYCLES cycles from leaving IDLE to re-entering IDLE.
REQ-023 VECTOR SHALL hold its value between sequences; D is ignored outside the P2_LOW sample cycle.

Reset
REQ-024 RESET=1 at a rising edge SHALL force IDLE, INTA=1, VECTOR=8'h00, VECTOR_VALID=0, ACK_ACTIVE=0, counter=0, from any state.
REQ-025 Reset mid-sequence SHALL abort without capturing a vector; RESET has priority over all other inputs.

Configuration
REQ-026 Macro INTA_SPURIOUS_EN SHALL, when defined, add output SPURIOUS (1 bit, reset 0).
REQ-027 With INTA_SPURIOUS_EN, INT sampled 0 on the last P1_LOW cycle SHALL skip GAP/P2_LOW, go to RECOVER, pulse SPURIOUS one cycle, leave VECTOR unchanged and VECTOR_VALID 0.
REQ-028 Without INTA_SPURIOUS_EN, SPURIOUS SHALL not exist and REQ-021 applies.

Verification
REQ-029 Defaults, INT=1, IF_EN=1, BUSY=0 from cycle 0, D=8'h4A in P2_LOW -> INTA low cycles 1-2 and 5-6, VECTOR=8'h4A with VECTOR_VALID at cycle 7, ACK_ACTIVE cycles 1-8.
REQ-030 INT=1 with BUSY=1 for 5 cycles then BUSY=0 -> INTA stays 1 during BUSY, first low one cycle after BUSY falls.
REQ-031 RESET pulsed during GAP -> INTA=1 and ACK_ACTIVE=0 next cycle, VECTOR keeps 8'h00, no VECTOR_VALID.
REQ-032 INT held high through two back-to-back acknowledges, D=8'h20 then 8'h21 -> four INTA pulses, VECTOR_VALID twice, VECTOR 8'h20 then 8'h21.
REQ-033 INTA_SPURIOUS_EN defined, INT dropped during P1_LOW -> one INTA pulse only, SPURIOUS one cycle, VECTOR unchanged; undefined -> two pulses, VECTOR_VALID asserted.

Source files
------------

// File: rtl/inta_initiator_if.sv
// Acknowledge bus between the interrupt-acknowledge initiator and its controller.
// SPURIOUS exists only when INTA_SPURIOUS_EN is defined.
interface inta_initiator_if;
   logic       INT;
   logic       IF_EN;
   logic       BUSY;
   logic [7:0] D;
   logic       INTA;
   logic [7:0] VECTOR;
   logic       VECTOR_VALID;
   logic       ACK_ACTIVE;
`ifdef INTA_SPURIOUS_EN
   logic       SPURIOUS;
`endif

   modport master (
      input  INT, IF_EN, BUSY, D,
      output INTA, VECTOR, VECTOR_VALID, ACK_ACTIVE
`ifdef INTA_SPURIOUS_EN
      , output SPURIOUS
`endif
   );

   modport slave (
      output INT, IF_EN, BUSY, D,
      input  INTA, VECTOR, VECTOR_VALID, ACK_ACTIVE
`ifdef INTA_SPURIOUS_EN
      , input SPURIOUS
`endif
   );
endinterface

// File: rtl/inta_initiator.sv
// Two-pulse interrupt-acknowledge initiator: INTA low, gap, INTA low with vector capture, recovery.
// Optional macro INTA_SPURIOUS_EN aborts to recovery when INT has vanished by the end of the first pulse.
module inta_initiator #(
   parameter int unsigned PULSE_LOW  = 2,
   parameter int unsigned GAP_CYCLES = 2
) (
   input logic              CLK,
   input logic              RESET,
   inta_initiator_if.master bus
);
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned VEC_W   = 8;
   localparam int unsigned PL_EFF  = (PULSE_LOW  == 0) ? 1 : PULSE_LOW;
   localparam int unsigned GAP_EFF = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
   localparam logic [CNT_W-1:0] PL_LAST  = CNT_W'(PL_EFF - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_EFF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_P1_LOW,
      S_GAP,
      S_P2_LOW,
      S_RECOVER
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [VEC_W-1:0]   vector_q, vector_d;
   logic               valid_q, valid_d;
   logic               inta_q, inta_d;
   logic               ack_q, ack_d;
`ifdef INTA_SPURIOUS_EN
   logic               spur_q, spur_d;
`endif

   // Next state; the counter holds the remaining cycles of the current phase minus one.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      vector_d = vector_q;
      valid_d  = 1'b0;
`ifdef INTA_SPURIOUS_EN
      spur_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.INT && bus.IF_EN && !bus.BUSY) begin
               state_d = S_P1_LOW;
               cnt_d   = PL_LAST;
            end
         end
         S_P1_LOW: begin
            if (cnt_q == '0) begin
               state_d = S_GAP;
               cnt_d   = GAP_LAST;
`ifdef INTA_SPURIOUS_EN
               if (!bus.INT) begin
                  state_d = S_RECOVER;
                  spur_d  = 1'b1;
               end
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_P2_LOW;
               cnt_d   = PL_LAST;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_P2_LOW: begin
            if (cnt_q == '0) begin
               state_d  = S_RECOVER;
               cnt_d    = GAP_LAST;
               vector_d = bus.D;
               valid_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RECOVER: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs follow the upcoming state so every output stays a plain flop.
      inta_d = !((state_d == S_P1_LOW) || (state_d == S_P2_LOW));
      ack_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         vector_q <= '0;
         valid_q  <= 1'b0;
         inta_q   <= 1'b1;
         ack_q    <= 1'b0;
`ifdef INTA_SPURIOUS_EN
         spur_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         vector_q <= vector_d;
         valid_q  <= valid_d;
         inta_q   <= inta_d;
         ack_q    <= ack_d;
`ifdef INTA_SPURIOUS_EN
         spur_q   <= spur_d;
`endif
      end
   end

   assign bus.INTA         = inta_q;
   assign bus.VECTOR       = vector_q;
   assign bus.VECTOR_VALID = valid_q;
   assign bus.ACK_ACTIVE   = ack_q;
`ifdef INTA_SPURIOUS_EN
   assign bus.SPURIOUS     = spur_q;
`endif

endmodule

// File: tb/tb_inta_initiator.sv
// Directed and randomized bench for inta_initiator against a sequence-position reference model.
module tb_inta_initiator;
   localparam int PL     = 2;
   localparam int GAP    = 2;
   localparam int P2_END = 2*PL + GAP;
   localparam int SEQ_LEN = 2*PL + 2*GAP;

   logic CLK;
   logic RESET;
   int   total;
   int   bad;

   // Model: position inside the acknowledge sequence (0 = idle, 1..SEQ_LEN = cycle of sequence).
   int         m_pos;
   logic [7:0] m_vec;
   logic       m_valid;
   logic       m_spur;

   inta_initiator_if bus ();

   inta_initiator #(.PULSE_LOW(PL), .GAP_CYCLES(GAP)) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic model_inta();
      return !(((m_pos >= 1) && (m_pos <= PL)) ||
               ((m_pos >= PL + GAP + 1) && (m_pos <= P2_END)));
   endfunction

   // One clock: model consumes the inputs present at the edge, then all outputs are compared.
   task automatic tick();
      logic       s_rst, s_int, s_ifen, s_busy;
      logic [7:0] s_d;
      s_rst  = RESET;
      s_int  = bus.INT;
      s_ifen = bus.IF_EN;
      s_busy = bus.BUSY;
      s_d    = bus.D;
      @(posedge CLK);
      if (s_rst) begin
         m_pos = 0; m_vec = 8'h00; m_valid = 1'b0; m_spur = 1'b0;
      end else begin
         m_valid = 1'b0;
         m_spur  = 1'b0;
         if (m_pos == 0) begin
            m_pos = (s_int && s_ifen && !s_busy) ? 1 : 0;
         end else if (m_pos == SEQ_LEN) begin
            m_pos = 0;
         end else if (m_pos == P2_END) begin
            m_vec   = s_d;
            m_valid = 1'b1;
            m_pos   = m_pos + 1;
`ifdef INTA_SPURIOUS_EN
         end else if ((m_pos == PL) && !s_int) begin
            m_spur = 1'b1;
            m_pos  = P2_END + 1;
`endif
         end else begin
            m_pos = m_pos + 1;
         end
      end
      #1;
      check("inta",  8'(bus.INTA),         8'(model_inta()));
      check("ack",   8'(bus.ACK_ACTIVE),   8'(m_pos != 0));
      check("valid", 8'(bus.VECTOR_VALID), 8'(m_valid));
      check("vector", bus.VECTOR,          m_vec);
`ifdef INTA_SPURIOUS_EN
      check("spurious", 8'(bus.SPURIOUS),  8'(m_spur));
`endif
   endtask

   initial begin
      int         pulses;
      int         valids;
      int         spurs;
      logic       prev_inta;
      logic [7:0] vec_before;

      total = 0;
      bad   = 0;
      m_pos = 0; m_vec = 8'h00; m_valid = 1'b0; m_spur = 1'b0;
      RESET = 1'b1;
      bus.INT = 1'b0; bus.IF_EN = 1'b0; bus.BUSY = 1'b0; bus.D = 8'h00;
      tick();
      tick();
      check("rst_inta",   8'(bus.INTA),         8'h01);
      check("rst_ack",    8'(bus.ACK_ACTIVE),   8'h00);
      check("rst_vector", bus.VECTOR,           8'h00);
      check("rst_valid",  8'(bus.VECTOR_VALID), 8'h00);
      RESET = 1'b0;

      // Reset during the gap aborts without a capture.
      bus.INT = 1'b1; bus.IF_EN = 1'b1; bus.D = 8'h5C;
      tick(); tick(); tick();
      check("gap_inta_high", 8'(bus.INTA), 8'h01);
      check("gap_ack",       8'(bus.ACK_ACTIVE), 8'h01);
      RESET = 1'b1; bus.INT = 1'b0;
      tick();
      check("abort_inta",   8'(bus.INTA),         8'h01);
      check("abort_ack",    8'(bus.ACK_ACTIVE),   8'h00);
      check("abort_vector", bus.VECTOR,           8'h00);
      check("abort_valid",  8'(bus.VECTOR_VALID), 8'h00);
      RESET = 1'b0;
      tick();

      // Basic acknowledge with vector 4A.
      bus.INT = 1'b1; bus.D = 8'h4A;
      for (int n = 1; n <= 9; n++) begin
         if (n == 9) bus.INT = 1'b0;
         tick();
         check($sformatf("basic_inta_c%0d", n), 8'(bus.INTA),
               8'(!((n == 1) || (n == 2) || (n == 5) || (n == 6))));
         check($sformatf("basic_ack_c%0d", n), 8'(bus.ACK_ACTIVE), 8'(n <= 8));
         check($sformatf("basic_valid_c%0d", n), 8'(bus.VECTOR_VALID), 8'(n == 7));
         if (n >= 7) check("basic_vector", bus.VECTOR, 8'h4A);
      end
      tick();

      // BUSY blocks the start; sequence begins one cycle after it falls.
      bus.INT = 1'b1; bus.BUSY = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("busy_hold", 8'(bus.INTA), 8'h01);
      end
      bus.BUSY = 1'b0;
      tick();
      check("busy_release", 8'(bus.INTA), 8'h00);
      bus.BUSY = 1'b1; bus.IF_EN = 1'b0;
      for (int n = 0; n < 7; n++) tick();
      bus.INT = 1'b0; bus.BUSY = 1'b0; bus.IF_EN = 1'b1;
      tick();
      tick();
      check("busy_done_ack", 8'(bus.ACK_ACTIVE), 8'h00);

      // Back-to-back acknowledges with INT held high.
      bus.INT = 1'b1; bus.D = 8'h20;
      pulses = 0; valids = 0; prev_inta = 1'b1;
      for (int n = 1; n <= 18; n++) begin
         if (n == 18) bus.INT = 1'b0;
         tick();
         if (prev_inta && !bus.INTA) pulses++;
         prev_inta = bus.INTA;
         if (bus.VECTOR_VALID) begin
            valids++;
            check("b2b_vector", bus.VECTOR, (valids == 1) ? 8'h20 : 8'h21);
            bus.D = 8'h21;
         end
      end
      check("b2b_pulses", 8'(pulses), 8'd4);
      check("b2b_valids", 8'(valids), 8'd2);
      tick();

      // INT dropped during the first pulse.
      vec_before = bus.VECTOR;
      bus.INT = 1'b1; bus.D = 8'h77;
      pulses = 0; valids = 0; spurs = 0; prev_inta = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         tick();
         bus.INT = 1'b0;
         if (prev_inta && !bus.INTA) pulses++;
         prev_inta = bus.INTA;
         if (bus.VECTOR_VALID) valids++;
`ifdef INTA_SPURIOUS_EN
         if (bus.SPURIOUS) spurs++;
`endif
      end
`ifdef INTA_SPURIOUS_EN
      check("drop_pulses", 8'(pulses), 8'd1);
      check("drop_spur",   8'(spurs),  8'd1);
      check("drop_valids", 8'(valids), 8'd0);
      check("drop_vector", bus.VECTOR, vec_before);
`else
      check("drop_pulses", 8'(pulses), 8'd2);
      check("drop_spur",   8'(spurs),  8'd0);
      check("drop_valids", 8'(valids), 8'd1);
      check("drop_vector", bus.VECTOR, 8'h77);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 500; n++) begin
         RESET      = ($urandom_range(0, 59) == 0);
         bus.INT    = ($urandom_range(0, 3) != 0);
         bus.IF_EN  = ($urandom_range(0, 3) != 0);
         bus.BUSY   = ($urandom_range(0, 2) == 0);
         bus.D      = 8'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
